// File: rtl/piece_placer.sv
// rtl/piece_placer.sv - spawns a tetromino and writes its four cells to the board
// Optional PIECE_RANDOM_EN: LFSR-driven piece selection instead of the fixed I..L cycle.
module piece_placer #(
    parameter int         BOARD_COLS = 10,
    parameter int         SPAWN_COL  = 3,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       placed,
    output logic       we,
    output logic [7:0] addr,
    output logic [7:0] data,
    output logic [7:0] reg_1_addr,
    output logic [7:0] reg_2_addr,
    output logic [7:0] reg_3_addr,
    output logic [7:0] reg_4_addr
);

    typedef enum logic [2:0] {IDLE, LOAD, W1, W2, W3, W4, DONE} state_t;

    localparam logic [7:0] COLS8  = 8'(BOARD_COLS);
    localparam logic [7:0] SPAWN8 = 8'(SPAWN_COL);

    state_t     state;
    logic [2:0] code;
    logic [2:0] next_code;

    // Each shape packs four {row, col[1:0]} offsets, block 1 in the top bits.
    function automatic logic [11:0] shape(input logic [2:0] c);
        case (c)
            3'd1:    shape = {3'b000, 3'b001, 3'b010, 3'b011};
            3'd2:    shape = {3'b001, 3'b010, 3'b101, 3'b110};
            3'd3:    shape = {3'b000, 3'b001, 3'b010, 3'b101};
            3'd4:    shape = {3'b001, 3'b010, 3'b100, 3'b101};
            3'd5:    shape = {3'b000, 3'b001, 3'b101, 3'b110};
            3'd6:    shape = {3'b000, 3'b100, 3'b101, 3'b110};
            3'd7:    shape = {3'b010, 3'b100, 3'b101, 3'b110};
            default: shape = 12'd0;
        endcase
    endfunction

    function automatic logic [7:0] blk_addr(input logic [11:0] sh, input int k);
        logic [2:0] o;
        o = sh[11-3*k -: 3];
        blk_addr = {7'd0, o[2]} * COLS8 + SPAWN8 + {6'd0, o[1:0]};
    endfunction

`ifdef PIECE_RANDOM_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_mod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign lfsr_mod  = (lfsr % 8'd7) + 8'd1;
    assign next_code = lfsr_mod[2:0];
`else
    logic [2:0] seq;
    wire  [7:0] unused_seed = LFSR_SEED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq <= 3'd1;
        end else if (state == LOAD) begin
            seq <= (seq == 3'd7) ? 3'd1 : seq + 3'd1;
        end
    end

    assign next_code = seq;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            code       <= 3'd0;
            placed     <= 1'b0;
            we         <= 1'b0;
            addr       <= 8'd0;
            data       <= 8'd0;
            reg_1_addr <= 8'd0;
            reg_2_addr <= 8'd0;
            reg_3_addr <= 8'd0;
            reg_4_addr <= 8'd0;
        end else begin
            we   <= 1'b0;
            addr <= 8'd0;
            data <= 8'd0;
            case (state)
                IDLE: begin
                    if (en) state <= LOAD;
                end
                LOAD: begin
                    code       <= next_code;
                    reg_1_addr <= blk_addr(shape(next_code), 0);
                    reg_2_addr <= blk_addr(shape(next_code), 1);
                    reg_3_addr <= blk_addr(shape(next_code), 2);
                    reg_4_addr <= blk_addr(shape(next_code), 3);
                    state      <= W1;
                end
                W1: begin
                    we    <= 1'b1;
                    addr  <= reg_1_addr;
                    data  <= {5'd0, code};
                    state <= W2;
                end
                W2: begin
                    we    <= 1'b1;
                    addr  <= reg_2_addr;
                    data  <= {5'd0, code};
                    state <= W3;
                end
                W3: begin
                    we    <= 1'b1;
                    addr  <= reg_3_addr;
                    data  <= {5'd0, code};
                    state <= W4;
                end
                W4: begin
                    we    <= 1'b1;
                    addr  <= reg_4_addr;
                    data  <= {5'd0, code};
                    state <= DONE;
                end
                DONE: begin
                    // First DONE edge raises placed; it then waits for en to drop.
                    if (!placed) begin
                        placed <= 1'b1;
                    end else if (!en) begin
                        placed <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_placer.sv
// tb/tb_piece_placer.sv - randomized self-checking bench for piece_placer
module tb_piece_placer;

    localparam int COLS  = 10;
    localparam int SPAWN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       placed;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] reg_1_addr;
    logic [7:0] reg_2_addr;
    logic [7:0] reg_3_addr;
    logic [7:0] reg_4_addr;

    int checks = 0;
    int errors = 0;
    int next_code = 1;

    // Shape offsets indexed by piece code (entry 0 unused).
    int srow [8][4] = '{'{0,0,0,0}, '{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1},
                        '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};
    int scol [8][4] = '{'{0,0,0,0}, '{0,1,2,3}, '{1,2,1,2}, '{0,1,2,1},
                        '{1,2,0,1}, '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};

    piece_placer dut (
        .clk(clk), .rst(rst), .en(en), .placed(placed), .we(we),
        .addr(addr), .data(data),
        .reg_1_addr(reg_1_addr), .reg_2_addr(reg_2_addr),
        .reg_3_addr(reg_3_addr), .reg_4_addr(reg_4_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int c, input int k);
        return srow[c][k] * COLS + SPAWN + scol[c][k];
    endfunction

    task automatic check_regs(input int c);
        check("reg_1_addr", reg_1_addr, exp_addr(c, 0));
        check("reg_2_addr", reg_2_addr, exp_addr(c, 1));
        check("reg_3_addr", reg_3_addr, exp_addr(c, 2));
        check("reg_4_addr", reg_4_addr, exp_addr(c, 3));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_placed"}, placed, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_regs"}, {reg_1_addr, reg_2_addr, reg_3_addr, reg_4_addr}, 0);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_we", we, 0);
            check("idle_placed", placed, 0);
        end
    endtask

    // hold: edges at which en is sampled high; abort_c: cycle to assert reset (0 = none).
    task automatic place(input int hold, input int abort_c);
        int code;
        int last;
        last = (hold > 7) ? hold : 7;
        code = next_code;
        next_code = next_code % 7 + 1;
        @(negedge clk);
        en = 1'b1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
`ifdef PIECE_RANDOM_EN
                if (c == 2) begin
                    code = int'(data);
                    check("code_range", (data >= 8'd1 && data <= 8'd7), 1);
                    if (data >= 8'd1 && data <= 8'd7) check_regs(code);
                end
`endif
                check("wr_we", we, 1);
                if (code >= 1 && code <= 7) check("wr_addr", addr, exp_addr(code, c - 2));
                check("wr_data", data, code);
                check("wr_placed", placed, 0);
            end else begin
`ifndef PIECE_RANDOM_EN
                if (c == 1) check_regs(code);
`endif
                check("quiet_we", we, 0);
                check("quiet_addr", addr, 0);
                check("quiet_data", data, 0);
                check("placed", placed, (c >= 6 && c < last));
            end
`ifndef PIECE_RANDOM_EN
            if (c == last) check("reg_hold", reg_4_addr, exp_addr(code, 3));
`endif
            if (c == abort_c) begin
                rst = 1'b0;
                #1;
                check_all_zero("abort");
                en = 1'b0;
                next_code = 1;
                @(negedge clk);
                rst = 1'b1;
                idle(6);
                return;
            end
            en = (c + 1 < hold);
        end
        en = 1'b0;
    endtask

    initial begin
        int n_rand;
        rst = 1'b0;
        en  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        place(14, 0);
        place(14, 0);
        for (int i = 0; i < 6; i++) begin
            place($urandom_range(1, 10), 0);
            idle($urandom_range(0, 2));
        end
        place(1, 0);
        place(2, 0);
        place(5, 3);
        place(8, 0);

`ifdef PIECE_RANDOM_EN
        n_rand = 100;
`else
        n_rand = 40;
`endif
        for (int i = 0; i < n_rand; i++) begin
            place($urandom_range(1, 12),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0);
            idle($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piece_placer.md
Name: piece_placer

Overview:
- Spawns a new Tetris piece onto the playfield register file.
- On `en`, it selects the next piece type and computes the cell addresses of its four blocks at the spawn position.
- It writes the piece code into those four cells through a single write port, then asserts `placed`.
- It sits between the game controller, which drives `en`, and the board memory, which receives `we`/`addr`/`data`. The four block addresses are exported for the piece-mover logic.

Parameters:
- BOARD_COLS, 10: cells per board row. Linear cell address = row*BOARD_COLS + col. 20 rows fit in 8 bits.
- SPAWN_COL, 3: column of the piece bounding-box origin. The spawn row is always 0.
- LFSR_SEED, 8'hA5: reset value of the random generator. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  request to place a new piece; level sensitive.
- placed  out  1  high while the placement is complete.
- we  out  1  board write enable.
- addr  out  8  board write address.
- data  out  8  board write data (piece code).
- reg_1_addr  out  8  cell address of block 1 of the active piece.
- reg_2_addr  out  8  cell address of block 2.
- reg_3_addr  out  8  cell address of block 3.
- reg_4_addr  out  8  cell address of block 4.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - placed, we, addr, data and reg_1..4_addr all go to 0.
  - The piece selector returns to its initial value: next piece is I, or LFSR=LFSR_SEED with the optional feature.
  - Reset in any state aborts immediately. we drops without waiting for a clock.
- Piece codes: I=1, O=2, T=3, S=4, Z=5, J=6, L=7. Code 0 means an empty cell and is never written.
- Block offsets as (row,col) relative to (0,SPAWN_COL), listed in block order 1..4:
  - I: (0,0)(0,1)(0,2)(0,3)
  - O: (0,1)(0,2)(1,1)(1,2)
  - T: (0,0)(0,1)(0,2)(1,1)
  - S: (0,1)(0,2)(1,0)(1,1)
  - Z: (0,0)(0,1)(1,1)(1,2)
  - J: (0,0)(1,0)(1,1)(1,2)
  - L: (0,2)(1,0)(1,1)(1,2)
  - Address arithmetic is 8-bit unsigned. With the defaults, all addresses fall in 3..15.
- FSM states: IDLE, LOAD, W1, W2, W3, W4, DONE.
  - IDLE: en=1 at an edge → LOAD.
  - LOAD (1 cycle):
    - Latches the current piece code.
    - reg_1..4_addr update at the exit edge.
    - The selector advances to the next piece.
  - W1..W4 (1 cycle each):
    - we=1, addr=reg_k_addr, data=code.
    - Outputs are registered, so a write is visible during the cycle after entering Wk.
  - DONE:
    - placed=1, we=0.
    - Stays in DONE while en=1. On en=0 → IDLE and placed clears.
- Latency: with en sampled at edge N, the writes occupy the cycles after edges N+2..N+5, and placed=1 from edge N+6.
- Once LOAD is entered, the sequence is atomic. Dropping en mid-write does not abort. The FSM reaches DONE, holds placed for 1 cycle, then returns to IDLE.
- en held high after DONE does not start a second piece. en must go low and then high again.
- When we=0, addr and data hold 0.
- reg_1..4_addr hold their last values until the next LOAD or reset.
- Default piece sequence: I,O,T,S,Z,J,L, then wraps back to I.

Optional Feature:
- Macro PIECE_RANDOM_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) steps every clock and resets to LFSR_SEED.
  - At LOAD, the piece code is (LFSR mod 7)+1.
- Undefined: the deterministic cyclic sequence above is used. The LFSR is not built.

Test Plan:
- Reset → all outputs 0, state IDLE; rst low mid-W2 → we=0 immediately, no further writes after release.
- Reset, then en=1 held for 14 cycles → reg addrs 3,4,5,6; writes (3,1),(4,1),(5,1),(6,1) on consecutive cycles; placed=1 from edge 6 until en=0.
- Second placement after en low-high with no reset → O piece: reg addrs 4,5,14,15; data=2 on all four writes.
- 8 placements without reset → codes 1..7 then 1 again. Check J: 3,13,14,15. Check L: 5,13,14,15.
- en high for 1 cycle only → full 4-write sequence completes; placed pulses for exactly 1 cycle; next en rising edge starts a new piece.
- Build with PIECE_RANDOM_EN: 100 placements → every data value in 1..7; each piece's 4 addresses match its code's shape table.
